fast9_corner_collector: RTL
===========================

// Module: fast9_corner_collector
// PURPOSE
//  Sink-side consumer of the FAST-9 output stream (outAddr/outPixel from FAST9_Top after NMS).
//  Captures every pixel carrying the corner marker 8'hA5, buffers its linear address,
//  converts it to (x,y) with a sequential divider, and presents corners over valid/ready.
//  Also reports per-frame corner count and frame completion for the host/readout logic.
// PARAMETERS
//  IMG_W      180     image width in pixels (x range 0..IMG_W-1)
//  IMG_H      180     image height in pixels (y range 0..IMG_H-1)
//  ADDR_W     15      width of linear pixel address
//  COORD_W    8       width of cornerX/cornerY
//  FIFO_DEPTH 8       address buffer depth, power of two
//  MARKER     8'hA5   pixel value that marks a corner
// PORTS
//  clock        in   1        single clock, all logic on rising edge
//  nReset       in   1        asynchronous, active-low reset
//  inAddr       in   ADDR_W   linear address of incoming pixel (y*IMG_W + x)
//  inPixel      in   8        incoming pixel value
//  inValid      in   1        inAddr/inPixel valid this cycle (tied high at top level)
//  cornerX      out  COORD_W  corner column, stable while cornerValid
//  cornerY      out  COORD_W  corner row, stable while cornerValid
//  cornerValid  out  1        corner available
//  cornerReady  in   1        consumer accepts corner when cornerValid&&cornerReady
//  cornerCount  out  16       corners accepted in current frame
//  frameCorners out  16       cornerCount latched at end of previous frame
//  frameDone    out  1        one-cycle pulse at end of frame
//  overflow     out  1        sticky: marker dropped because FIFO full
//  addrError    out  1        sticky: marker with inAddr >= IMG_W*IMG_H
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, FSM in IDLE; reset mid-operation discards everything.
//  Capture: at edge N, inValid && inPixel==MARKER && inAddr<IMG_W*IMG_H && !full -> push inAddr,
//   cornerCount+1 (saturates at 16'hFFFF). If full -> drop, overflow<=1, count unchanged.
//   If inAddr out of range -> drop, addrError<=1. Non-marker pixels ignored.
//  FIFO: push when full and pop in same cycle -> push accepted (pop frees slot first).
//   Pointers wrap modulo FIFO_DEPTH; one extra bit distinguishes full/empty.
//  FSM IDLE -> DIV -> OUT -> IDLE:
//   IDLE: FIFO non-empty -> pop, dividend<=addr, divisor IMG_W, go DIV.
//   DIV: restoring division, one quotient bit per cycle, exactly ADDR_W cycles;
//    last cycle registers cornerY=quotient, cornerX=remainder, go OUT.
//   OUT: cornerValid=1; X/Y held until cornerValid&&cornerReady, then IDLE (cornerValid=0 next cycle).
//  Latency: marker at edge N into empty FIFO/IDLE FSM -> pop at N+1 -> cornerValid high after
//   edge N+1+ADDR_W (N+16 at defaults). Throughput one corner per ADDR_W+2 cycles max.
//  Frame end: inValid && inAddr==IMG_W*IMG_H-1 -> next cycle frameDone=1 for one cycle,
//   frameCorners<=cornerCount (including a marker on that same last pixel), cornerCount<=0.
//  Sticky flags cleared only by reset. Ordering of corners out == order of capture.
//  Quotient/remainder fit COORD_W for defaults; IMG_W,IMG_H <= 2**COORD_W required (elab check).
// STRUCTURE
//  fast9_pkg: MARKER, IMG_W, IMG_H, ADDR_W, COORD_W constants; FSM state enum (IDLE/DIV/OUT).
//  Sub-module corner_addr_fifo (sync FIFO, parameterised DEPTH/WIDTH, push/pop/full/empty).
//  Top holds capture logic, counters, divider datapath and FSM.
// TESTING
//  1 Single marker at inAddr=185 (IMG_W=180) -> cornerValid after 16 edges, X=5,Y=1; count=1.
//  2 Markers at 0 and 32399 back-to-back, cornerReady=1 -> (0,0) then (179,179) in order;
//    frameDone pulse after addr 32399, frameCorners=2, cornerCount=0.
//  3 cornerReady=0, 10 consecutive markers -> 8 buffered + 1 in FSM, 10th dropped, overflow=1;
//    release ready -> exactly 9 corners out, X/Y stable while stalled.
//  4 Full FIFO with pop and marker in same cycle -> marker accepted, overflow stays 0.
//  5 Marker at inAddr=32400 -> no corner, addrError=1, count unchanged; inPixel=8'hA4 ignored.
//  6 nReset low during DIV with 3 queued -> all outputs 0, FIFO empty, no stale corner after release.

Source files
------------

// File: rtl/fast9_corner_collector_pkg.sv
// Shared constants for the FAST-9 corner collector: default geometry, corner marker,
// FSM state encodings and a saturating counter helper.
package fast9_corner_collector_pkg;

  localparam int unsigned ImgW      = 180;
  localparam int unsigned ImgH      = 180;
  localparam int unsigned AddrW     = 15;
  localparam int unsigned CoordW    = 8;
  localparam int unsigned FifoDepth = 8;
  localparam logic [7:0]  Marker    = 8'hA5;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StDiv  = 2'd1;
  localparam logic [1:0] StOut  = 2'd2;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fast9_corner_collector_fifo.sv
// Synchronous address FIFO; pointers carry one extra wrap bit to tell full from empty.
// A push while full is accepted when a pop happens in the same cycle.
module fast9_corner_collector_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 15
) (
  input  logic             clock,
  input  logic             nReset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] PtrOne = {{PtrW{1'b0}}, 1'b1};

  logic [PtrW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
               (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PtrOne : rd_ptr_q;
    rdata    = mem_q[rd_ptr_q[PtrW-1:0]];
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fast9_corner_collector.sv
// Captures marker pixels from the FAST-9 stream, converts each linear address to (x,y)
// with a restoring divider, and streams corners out over valid/ready with frame statistics.
module fast9_corner_collector
  import fast9_corner_collector_pkg::*;
#(
  parameter int unsigned IMG_W      = ImgW,
  parameter int unsigned IMG_H      = ImgH,
  parameter int unsigned ADDR_W     = AddrW,
  parameter int unsigned COORD_W    = CoordW,
  parameter int unsigned FIFO_DEPTH = FifoDepth,
  parameter logic [7:0]  MARKER     = Marker
) (
  input  logic               clock,
  input  logic               nReset,
  input  logic [ADDR_W-1:0]  inAddr,
  input  logic [7:0]         inPixel,
  input  logic               inValid,
  output logic [COORD_W-1:0] cornerX,
  output logic [COORD_W-1:0] cornerY,
  output logic               cornerValid,
  input  logic               cornerReady,
  output logic [15:0]        cornerCount,
  output logic [15:0]        frameCorners,
  output logic               frameDone,
  output logic               overflow,
  output logic               addrError
);

  localparam int unsigned NumPix = IMG_W * IMG_H;
  localparam int unsigned RemW   = $clog2(IMG_W) + 1;
  localparam int unsigned CntW   = $clog2(ADDR_W);
  localparam logic [ADDR_W:0]   NumPixW  = (ADDR_W + 1)'(NumPix);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NumPix - 1);
  localparam logic [RemW-1:0]   Divisor  = RemW'(IMG_W);
  localparam logic [CntW-1:0]   LastCnt  = CntW'(ADDR_W - 1);

  if (IMG_W > (2 ** COORD_W) || IMG_H > (2 ** COORD_W)) begin : gen_coord_chk
    $error("IMG_W and IMG_H must not exceed 2**COORD_W");
  end
  if (NumPix > (2 ** ADDR_W)) begin : gen_addr_chk
    $error("IMG_W*IMG_H must fit in ADDR_W bits");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gen_depth_chk
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  dvd_q, dvd_d;  // dividend shifts out the top, quotient shifts in below
  logic [RemW-1:0]    rem_q, rem_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [15:0]        count_q, count_d, frame_corners_q, frame_corners_d, count_inc;
  logic               frame_done_q, frame_done_d;
  logic               overflow_q, overflow_d, addr_err_q, addr_err_d;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ADDR_W-1:0]  fifo_rdata;
  logic               is_marker, in_range, frame_end;
  logic [RemW-1:0]    rem_shift, rem_next;
  logic [ADDR_W-1:0]  q_next;
  logic               rem_ge;

  fast9_corner_collector_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_W)
  ) u_fifo (
    .clock  (clock),
    .nReset (nReset),
    .push   (fifo_push),
    .wdata  (inAddr),
    .pop    (fifo_pop),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Capture, sticky flags and frame accounting.
  always_comb begin
    is_marker       = inValid && (inPixel == MARKER);
    in_range        = {1'b0, inAddr} < NumPixW;
    frame_end       = inValid && (inAddr == LastAddr);
    fifo_push       = is_marker && in_range && (!fifo_full || fifo_pop);
    overflow_d      = overflow_q | (is_marker && in_range && fifo_full && !fifo_pop);
    addr_err_d      = addr_err_q | (is_marker && !in_range);
    count_inc       = fifo_push ? sat_inc16(count_q) : count_q;
    count_d         = frame_end ? 16'd0 : count_inc;
    frame_corners_d = frame_end ? count_inc : frame_corners_q;
    frame_done_d    = frame_end;
  end

  // One restoring-division step; the remainder never exceeds 2*IMG_W-1 before subtraction.
  always_comb begin
    rem_shift = (rem_q << 1) | {{(RemW - 1){1'b0}}, dvd_q[ADDR_W-1]};
    rem_ge    = rem_shift >= Divisor;
    rem_next  = rem_ge ? rem_shift - Divisor : rem_shift;
    q_next    = {dvd_q[ADDR_W-2:0], rem_ge};
  end

  always_comb begin
    state_d  = state_q;
    dvd_d    = dvd_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    fifo_pop = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          dvd_d    = fifo_rdata;
          rem_d    = '0;
          cnt_d    = '0;
          state_d  = StDiv;
        end
      end
      StDiv: begin
        dvd_d = q_next;
        rem_d = rem_next;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          x_d     = COORD_W'(rem_next);
          y_d     = COORD_W'(q_next);
          state_d = StOut;
        end
      end
      StOut: begin
        if (cornerReady) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q         <= StIdle;
      dvd_q           <= '0;
      rem_q           <= '0;
      cnt_q           <= '0;
      x_q             <= '0;
      y_q             <= '0;
      count_q         <= '0;
      frame_corners_q <= '0;
      frame_done_q    <= 1'b0;
      overflow_q      <= 1'b0;
      addr_err_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      dvd_q           <= dvd_d;
      rem_q           <= rem_d;
      cnt_q           <= cnt_d;
      x_q             <= x_d;
      y_q             <= y_d;
      count_q         <= count_d;
      frame_corners_q <= frame_corners_d;
      frame_done_q    <= frame_done_d;
      overflow_q      <= overflow_d;
      addr_err_q      <= addr_err_d;
    end
  end

  assign cornerX      = x_q;
  assign cornerY      = y_q;
  assign cornerValid  = (state_q == StOut);
  assign cornerCount  = count_q;
  assign frameCorners = frame_corners_q;
  assign frameDone    = frame_done_q;
  assign overflow     = overflow_q;
  assign addrError    = addr_err_q;

endmodule
